// File: rtl/cps_pkg.sv
// Shared definitions for the cross-point-switch configuration controller.
//   - state encoding used by cps_config_ctrl
//   - default chain length, clock divider and reset-hold length
//   - cnt_width(): counter width for a count range, never below 1 bit
package cps_pkg;

  localparam int unsigned CFG_BITS_DEF   = 32;
  localparam int unsigned DIV_DEF        = 4;
  localparam int unsigned RST_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    UPDATE
  } cps_state_t;

  // ceil(log2(n)), clamped so a range of 1 still gets a legal 1-bit vector
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cps_tick_gen.sv
// Phase counter for one CPS_clk half-period.
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   i_clr    in  hold the counter at 0 (states that are not timed)
//   o_tick_c out high on the last clk cycle of a DIV-cycle phase
// The counter restarts from 0 after every tick, and every tick is a state
// change in the controller, so each state starts with a fresh phase.
module cps_tick_gen
  import cps_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned PW = cnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] r_phase;

  assign o_tick_c = (r_phase == LAST);

  // counts 0..DIV-1 and restarts; never runs past LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (i_clr || o_tick_c) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/cps_config_ctrl.sv
// Serial configuration controller for a cross-point switch.
//   clk, reset    single clock domain, asynchronous active-high reset
//   cfg_data      configuration word, shifted MSB first
//   cfg_start     load request, accepted only in IDLE
//   busy          high during reset hold and transfers
//   done          one-cycle pulse at transfer completion
//   readback      chain content shifted out during the last transfer
//   CPS_clk, CPS_ce_n, CPS_datain, CPS_reset_n, CPS_update_n  switch side
//   CPS_dataout   serial data from the switch, synchronous to clk
// All outputs are registers written by the FSM below.
module cps_config_ctrl
  import cps_pkg::*;
#(
  parameter int unsigned CFG_BITS   = CFG_BITS_DEF,
  parameter int unsigned DIV        = DIV_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CFG_BITS-1:0] cfg_data,
  input  logic                cfg_start,
  output logic                busy,
  output logic                done,
  output logic [CFG_BITS-1:0] readback,
  output logic                CPS_clk,
  output logic                CPS_ce_n,
  output logic                CPS_datain,
  input  logic                CPS_dataout,
  output logic                CPS_reset_n,
  output logic                CPS_update_n
);

  localparam int unsigned BW = cnt_width(CFG_BITS);
  localparam int unsigned RW = cnt_width(RST_CYCLES);

  cps_state_t          r_state;
  logic [BW-1:0]       r_bit_cnt;
  logic [RW-1:0]       r_rst_cnt;
  logic [CFG_BITS-1:0] r_sr;
  logic                w_tick;
  logic                w_clr;

  // phase timing only runs in the DIV-timed states
  assign w_clr = (r_state == IDLE) || (r_state == RST_HOLD);

  cps_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .o_tick_c (w_tick)
  );

  // controller FSM; outputs are updated together with the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RST_HOLD;
      r_bit_cnt    <= '0;
      r_rst_cnt    <= '0;
      r_sr         <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      readback     <= '0;
      CPS_clk      <= 1'b0;
      CPS_ce_n     <= 1'b1;
      CPS_datain   <= 1'b0;
      CPS_reset_n  <= 1'b0;
      CPS_update_n <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        RST_HOLD: begin
          if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
            r_rst_cnt   <= '0;
            CPS_reset_n <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end
        IDLE: begin
          if (cfg_start) begin
            r_sr       <= cfg_data;
            r_bit_cnt  <= BW'(CFG_BITS - 1);
            CPS_datain <= cfg_data[CFG_BITS-1];
            CPS_ce_n   <= 1'b0;
            busy       <= 1'b1;
            r_state    <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          // rising CPS_clk edge: sample the bit the switch is presenting
          if (w_tick) begin
            CPS_clk  <= 1'b1;
            readback <= {readback[CFG_BITS-2:0], CPS_dataout};
            r_state  <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (w_tick) begin
            CPS_clk <= 1'b0;
            if (r_bit_cnt == '0) begin
              CPS_ce_n     <= 1'b1;
              CPS_update_n <= 1'b0;
              r_state      <= UPDATE;
            end else begin
              // next bit appears with the falling CPS_clk edge
              r_sr       <= {r_sr[CFG_BITS-2:0], 1'b0};
              CPS_datain <= r_sr[CFG_BITS-2];
              r_bit_cnt  <= r_bit_cnt - BW'(1);
              r_state    <= SHIFT_LO;
            end
          end
        end
        UPDATE: begin
          if (w_tick) begin
            CPS_update_n <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_cps_config_ctrl.sv
`timescale 1ns/1ps
module tb_cps_config_ctrl;
  import cps_pkg::*;

  localparam int NA = 32;
  localparam int DA = 4;
  localparam int NB = 4;
  localparam int DB = 1;
  localparam int LAT_A = 2*DA*NA + DA + 1;
  localparam int LAT_B = 2*DB*NB + DB + 1;

  typedef struct { int cyc; logic [31:0] rb; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // instance A: default build
  logic [NA-1:0] cfg_data_a = '0, readback_a;
  logic cfg_start_a = 1'b0;
  logic busy_a, done_a, clk_a, ce_n_a, datain_a, dataout_a, reset_n_a, update_n_a;
  // instance B: DIV=1, CFG_BITS=4
  logic [NB-1:0] cfg_data_b = '0, readback_b;
  logic cfg_start_b = 1'b0;
  logic busy_b, done_b, clk_b, ce_n_b, datain_b, dataout_b, reset_n_b, update_n_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cps_config_ctrl u_dut_a (
    .clk(clk), .reset(reset), .cfg_data(cfg_data_a), .cfg_start(cfg_start_a),
    .busy(busy_a), .done(done_a), .readback(readback_a),
    .CPS_clk(clk_a), .CPS_ce_n(ce_n_a), .CPS_datain(datain_a),
    .CPS_dataout(dataout_a), .CPS_reset_n(reset_n_a), .CPS_update_n(update_n_a)
  );

  cps_config_ctrl #(.CFG_BITS(NB), .DIV(DB), .RST_CYCLES(16)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_data(cfg_data_b), .cfg_start(cfg_start_b),
    .busy(busy_b), .done(done_b), .readback(readback_b),
    .CPS_clk(clk_b), .CPS_ce_n(ce_n_b), .CPS_datain(datain_b),
    .CPS_dataout(dataout_b), .CPS_reset_n(reset_n_b), .CPS_update_n(update_n_b)
  );

  // switch models: shift chain clocked by CPS_clk, MSB presented on dataout
  logic [NA-1:0] chain_a;
  logic [NB-1:0] chain_b;
  always @(posedge clk_a or negedge reset_n_a)
    if (!reset_n_a) chain_a <= '0; else chain_a <= {chain_a[NA-2:0], datain_a};
  always @(posedge clk_b or negedge reset_n_b)
    if (!reset_n_b) chain_b <= '0; else chain_b <= {chain_b[NB-2:0], datain_b};
  assign dataout_a = chain_a[NA-1];
  assign dataout_b = chain_b[NB-1];

  // scoreboards
  logic bitq_a[$];
  logic bitq_b[$];
  exp_t doneq_a[$];
  exp_t doneq_b[$];
  int n_rise_a = 0, n_done_a = 0, n_upd_a = 0, upd_len_a = 0, last_upd_a = 0, stab_a = 0;
  int n_rise_b = 0, n_done_b = 0, n_upd_b = 0, upd_len_b = 0, last_upd_b = 0, stab_b = 0;
  logic prev_clk_a = 1'b0, prev_din_a = 1'b0, held_a = 1'b0;
  logic prev_clk_b = 1'b0, prev_din_b = 1'b0, held_b = 1'b0;

  // monitor A, sampled 3 ns after the active edge
  always begin
    logic eb;
    exp_t e;
    @(posedge clk); #3;
    stab_a = (datain_a === prev_din_a) ? stab_a + 1 : 1;
    if (clk_a && !prev_clk_a) begin
      n_rise_a++; n_tests++;
      if (bitq_a.size() == 0) begin
        n_fail++; $display("FAIL bit_a: unexpected CPS_clk rise, datain=%0b", datain_a);
      end else begin
        eb = bitq_a.pop_front();
        if (datain_a !== eb || stab_a < DA + 1) begin
          n_fail++;
          $display("FAIL bit_a: datain=%0b stable=%0d, expected %0b stable>=%0d", datain_a, stab_a, eb, DA + 1);
        end
      end
      held_a = datain_a;
    end else if (clk_a) begin
      n_tests++;
      if (datain_a !== held_a) begin
        n_fail++; $display("FAIL hold_a: datain=%0b while CPS_clk high, expected %0b", datain_a, held_a);
      end
    end
    if (update_n_a === 1'b0) upd_len_a++;
    else if (upd_len_a != 0) begin n_upd_a++; last_upd_a = upd_len_a; upd_len_a = 0; end
    if (done_a) begin
      n_done_a++; n_tests++;
      if (doneq_a.size() == 0) begin
        n_fail++; $display("FAIL done_a: unexpected done at cycle %0d", cyc);
      end else begin
        e = doneq_a.pop_front();
        if (cyc != e.cyc || readback_a !== e.rb[NA-1:0]) begin
          n_fail++;
          $display("FAIL done_a: cycle=%0d readback=%h, expected cycle=%0d readback=%h", cyc, readback_a, e.cyc, e.rb);
        end
      end
    end
    prev_clk_a = clk_a;
    prev_din_a = datain_a;
  end

  // monitor B
  always begin
    logic eb;
    exp_t e;
    @(posedge clk); #3;
    stab_b = (datain_b === prev_din_b) ? stab_b + 1 : 1;
    if (clk_b && !prev_clk_b) begin
      n_rise_b++; n_tests++;
      if (bitq_b.size() == 0) begin
        n_fail++; $display("FAIL bit_b: unexpected CPS_clk rise, datain=%0b", datain_b);
      end else begin
        eb = bitq_b.pop_front();
        if (datain_b !== eb || stab_b < DB + 1) begin
          n_fail++;
          $display("FAIL bit_b: datain=%0b stable=%0d, expected %0b stable>=%0d", datain_b, stab_b, eb, DB + 1);
        end
      end
      held_b = datain_b;
    end else if (clk_b) begin
      n_tests++;
      if (datain_b !== held_b) begin
        n_fail++; $display("FAIL hold_b: datain=%0b while CPS_clk high, expected %0b", datain_b, held_b);
      end
    end
    if (update_n_b === 1'b0) upd_len_b++;
    else if (upd_len_b != 0) begin n_upd_b++; last_upd_b = upd_len_b; upd_len_b = 0; end
    if (done_b) begin
      n_done_b++; n_tests++;
      if (doneq_b.size() == 0) begin
        n_fail++; $display("FAIL done_b: unexpected done at cycle %0d", cyc);
      end else begin
        e = doneq_b.pop_front();
        if (cyc != e.cyc || {28'h0, readback_b} !== e.rb) begin
          n_fail++;
          $display("FAIL done_b: cycle=%0d readback=%h, expected cycle=%0d readback=%h", cyc, readback_b, e.cyc, e.rb);
        end
      end
    end
    prev_clk_b = clk_b;
    prev_din_b = datain_b;
  end

  // measures the RST_HOLD window; reset must have been released just after a posedge
  task automatic count_hold(output int lows, output logic busy_bad, output logic busy_after);
    lows = 0; busy_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (reset_n_a === 1'b0) begin
        lows++;
        if (busy_a !== 1'b1) busy_bad = 1'b1;
      end else break;
    end
    busy_after = busy_a;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy_a === 1'b0 && busy_b === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int lows, r0;
    logic bb, ba;
    @(negedge clk);
    n_tests++;
    if ({busy_a, done_a, clk_a, ce_n_a, datain_a, reset_n_a, update_n_a, readback_a} !== {7'b1001001, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_vals_a: got %b rb=%h, expected 1001001 rb=0",
               {busy_a, done_a, clk_a, ce_n_a, datain_a, reset_n_a, update_n_a}, readback_a);
    end
    n_tests++;
    if ({busy_b, done_b, clk_b, ce_n_b, datain_b, reset_n_b, update_n_b, readback_b} !== {7'b1001001, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_vals_b: got %b rb=%h, expected 1001001 rb=0",
               {busy_b, done_b, clk_b, ce_n_b, datain_b, reset_n_b, update_n_b}, readback_b);
    end
    r0 = n_rise_a;
    @(posedge clk); #1 reset = 1'b0;
    count_hold(lows, bb, ba);
    n_tests++;
    if (lows != 16 || bb !== 1'b0 || ba !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold: low=%0d busy_bad=%0b busy_after=%0b, expected 16 0 0", lows, bb, ba);
    end
    n_tests++;
    if (n_rise_a != r0 || ce_n_a !== 1'b1 || update_n_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_idle: rises=%0d ce_n=%0b update_n=%0b, expected 0 1 1", n_rise_a - r0, ce_n_a, update_n_a);
    end
  endtask

  task automatic test_transfer(input logic [31:0] data, input logic [31:0] exp_rb);
    int r0, d0, u0;
    logic ok;
    exp_t e;
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL xfer_idle: busy=%0b, expected 0", busy_a); end
    r0 = n_rise_a; d0 = n_done_a; u0 = n_upd_a;
    for (int i = NA - 1; i >= 0; i--) bitq_a.push_back(data[i]);
    e.cyc = cyc + LAT_A; e.rb = exp_rb;
    doneq_a.push_back(e);
    cfg_data_a = data; cfg_start_a = 1'b1;
    @(negedge clk);
    cfg_start_a = 1'b0; cfg_data_a = ~data;
    for (int i = 0; i < LAT_A + 20; i++) begin
      @(negedge clk);
      if (n_done_a != d0) break;
    end
    n_tests++;
    if (n_done_a - d0 != 1) begin n_fail++; $display("FAIL xfer_done: done pulses=%0d, expected 1", n_done_a - d0); end
    n_tests++;
    if (n_rise_a - r0 != NA || n_upd_a - u0 != 1 || last_upd_a != DA) begin
      n_fail++;
      $display("FAIL xfer_edges: rises=%0d upd=%0d width=%0d, expected %0d 1 %0d", n_rise_a - r0, n_upd_a - u0, last_upd_a, NA, DA);
    end
    n_tests++;
    if (chain_a !== data[NA-1:0] || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL xfer_chain: chain=%h busy=%0b, expected %h 0", chain_a, busy_a, data);
    end
  endtask

  task automatic test_start_spam;
    int r0, d0;
    logic ok;
    exp_t e;
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL spam_idle: busy=%0b, expected 0", busy_a); end
    r0 = n_rise_a; d0 = n_done_a;
    for (int i = NA - 1; i >= 0; i--) bitq_a.push_back(1'((32'h0F0F_F0F0 >> i) & 1));
    e.cyc = cyc + LAT_A; e.rb = 32'h1234_5678;
    doneq_a.push_back(e);
    cfg_data_a = 32'h0F0F_F0F0; cfg_start_a = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      cfg_data_a = $urandom;
    end
    cfg_start_a = 1'b0;
    repeat (300) @(negedge clk);
    n_tests++;
    if (n_done_a - d0 != 1 || n_rise_a - r0 != NA) begin
      n_fail++; $display("FAIL spam: done=%0d rises=%0d, expected 1 %0d", n_done_a - d0, n_rise_a - r0, NA);
    end
    n_tests++;
    if (chain_a !== 32'h0F0F_F0F0) begin n_fail++; $display("FAIL spam_chain: chain=%h, expected 0f0ff0f0", chain_a); end
  endtask

  task automatic test_abort;
    int r0, d0, u0, lows;
    logic ok, bb, ba;
    wait_idle(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL abort_idle: busy=%0b, expected 0", busy_a); end
    r0 = n_rise_a; d0 = n_done_a; u0 = n_upd_a;
    for (int i = NA - 1; i >= 0; i--) bitq_a.push_back(1'((32'hDEAD_BEEF >> i) & 1));
    cfg_data_a = 32'hDEAD_BEEF; cfg_start_a = 1'b1;
    @(negedge clk);
    cfg_start_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_rise_a - r0 >= 10) break;
      @(negedge clk);
    end
    n_tests++;
    if (n_rise_a - r0 != 10) begin n_fail++; $display("FAIL abort_bit: rises=%0d, expected 10", n_rise_a - r0); end
    reset = 1'b1;
    #1;
    bitq_a.delete();
    n_tests++;
    if ({busy_a, done_a, clk_a, ce_n_a, datain_a, reset_n_a, update_n_a, readback_a} !== {7'b1001001, 32'h0}) begin
      n_fail++;
      $display("FAIL abort_async: got %b rb=%h, expected 1001001 rb=0",
               {busy_a, done_a, clk_a, ce_n_a, datain_a, reset_n_a, update_n_a}, readback_a);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    count_hold(lows, bb, ba);
    repeat (5) @(negedge clk);
    n_tests++;
    if (lows != 16 || bb !== 1'b0 || ba !== 1'b0) begin
      n_fail++; $display("FAIL abort_hold: low=%0d busy_bad=%0b busy_after=%0b, expected 16 0 0", lows, bb, ba);
    end
    n_tests++;
    if (n_upd_a != u0 || n_done_a != d0 || n_rise_a - r0 != 10) begin
      n_fail++;
      $display("FAIL abort_quiet: upd=%0d done=%0d rises=%0d, expected 0 0 10", n_upd_a - u0, n_done_a - d0, n_rise_a - r0);
    end
  endtask

  task automatic test_small_build;
    logic [3:0] data [2];
    logic [3:0] rb [2];
    int r0, d0, u0;
    logic ok;
    exp_t e;
    data[0] = 4'hB; rb[0] = 4'h0;
    data[1] = 4'h6; rb[1] = 4'hB;
    for (int t = 0; t < 2; t++) begin
      wait_idle(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL small_idle: busy=%0b, expected 0", busy_b); end
      r0 = n_rise_b; d0 = n_done_b; u0 = n_upd_b;
      for (int i = NB - 1; i >= 0; i--) bitq_b.push_back(data[t][i]);
      e.cyc = cyc + LAT_B; e.rb = {28'h0, rb[t]};
      doneq_b.push_back(e);
      cfg_data_b = data[t]; cfg_start_b = 1'b1;
      @(negedge clk);
      cfg_start_b = 1'b0; cfg_data_b = ~data[t];
      repeat (LAT_B + 5) @(negedge clk);
      n_tests++;
      if (n_done_b - d0 != 1 || n_rise_b - r0 != NB || n_upd_b - u0 != 1 || last_upd_b != DB) begin
        n_fail++;
        $display("FAIL small_xfer: done=%0d rises=%0d upd=%0d width=%0d, expected 1 %0d 1 %0d",
                 n_done_b - d0, n_rise_b - r0, n_upd_b - u0, last_upd_b, NB, DB);
      end
      n_tests++;
      if (chain_b !== data[t]) begin n_fail++; $display("FAIL small_chain: chain=%h, expected %h", chain_b, data[t]); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_transfer(32'hA5C3_0F81, 32'h0000_0000);
    test_transfer(32'h1234_5678, 32'hA5C3_0F81);
    test_start_spam();
    test_abort();
    test_small_build();
    n_tests++;
    if (bitq_a.size() != 0 || doneq_a.size() != 0 || bitq_b.size() != 0 || doneq_b.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: left bits_a=%0d done_a=%0d bits_b=%0d done_b=%0d, expected all 0",
               bitq_a.size(), doneq_a.size(), bitq_b.size(), doneq_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
